// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame timing constants
// and the baud divider calculation used by both receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int         FRAME_BITS    = 8;
  localparam logic [3:0] MID_START_CNT = 4'd7;
  localparam logic [3:0] MID_BIT_CNT   = 4'd15;

  // Clocks per oversampling tick, truncated.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator: one-clk pulse every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampled framing FSM,
// sticky byte-available and overrun flags cleared by the peripheral.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  rx_state_t r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [2:0] r_idx, w_idx_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_status, w_status_next;
  logic       r_overrun, w_overrun_next;
  logic       r_valid, w_valid_next;
  logic       r_ferr, w_ferr_next;
  logic       r_rx_meta, r_rx_s;
  logic       w_tick;

  uart_baud_tick #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .OVS   (OVS)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
    w_rx_data_next = r_rx_data;
    w_status_next  = r_status;
    w_overrun_next = r_overrun;
    w_valid_next   = 1'b0;
    w_ferr_next    = 1'b0;

    if (rx_clear) begin
      w_status_next  = 1'b0;
      w_overrun_next = 1'b0;
    end

    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) begin
            w_state_next = ST_START;
            w_cnt_next   = '0;
          end
        end
        ST_START: begin
          if (r_cnt == MID_START_CNT) begin
            if (!r_rx_s) begin
              w_state_next = ST_DATA;
              w_cnt_next   = '0;
              w_idx_next   = '0;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == MID_BIT_CNT) begin
            w_shift_next[r_idx] = r_rx_s;
            w_cnt_next          = '0;
            w_idx_next          = r_idx + 3'd1;
            if (r_idx == 3'(FRAME_BITS - 1)) begin
              w_state_next = ST_STOP;
            end
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == MID_BIT_CNT) begin
            if (r_rx_s) begin
              // Completion beats a same-cycle clear; overrun is then left alone.
              w_rx_data_next = r_shift;
              w_valid_next   = 1'b1;
              w_status_next  = 1'b1;
              w_overrun_next = rx_clear ? r_overrun : (r_overrun | r_status);
              w_state_next   = ST_IDLE;
            end else begin
              w_ferr_next  = 1'b1;
              w_state_next = ST_BREAK;
            end
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        ST_BREAK: begin
          if (r_rx_s) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_status  <= 1'b0;
      r_overrun <= 1'b0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
      r_rx_data <= w_rx_data_next;
      r_status  <= w_status_next;
      r_overrun <= w_overrun_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_status = r_status;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver using a fast baud setting (DIV=5, 80 clk/bit)
// and an ideal 8N1 line driver.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CLK_HZ = 800000;
  localparam int BAUD   = 10000;
  localparam int OVS    = 16;
  localparam int DIV    = 5;
  localparam int BIT    = DIV * OVS;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       uart_rx  = 1'b1;
  logic       rx_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_checks  = 0;
  int n_errors  = 0;
  int valid_cnt = 0;
  int valid_run = 0;
  int valid_max = 0;
  int ferr_cnt  = 0;
  int ferr_run  = 0;
  int ferr_max  = 0;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .OVS   (OVS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_clear (rx_clear),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // Pulse monitor: counts pulses and records the longest run of each.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_run = valid_run + 1;
      if (valid_run > valid_max) valid_max = valid_run;
    end else begin
      valid_run = 0;
    end
    if (frame_err) begin
      ferr_cnt = ferr_cnt + 1;
      ferr_run = ferr_run + 1;
      if (ferr_run > ferr_max) ferr_max = ferr_run;
    end else begin
      ferr_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic level, input int n);
    uart_rx = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    line(stop, BIT);
    $display("tx frame 0x%02h stop=%0d rx_data=0x%02h status=%0d overrun=%0d",
             d, stop, rx_data, rx_status, overrun);
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int   v0;
    int   f0;
    logic hit;
    logic coincide;

    repeat (5) @(negedge clk);
    settle();
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_status", 32'(rx_status), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Plain frame
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1);
    line(1'b1, BIT);
    settle();
    check("f55_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("f55_valid_width", 32'(valid_max), 32'd1);
    check("f55_data", 32'(rx_data), 32'h55);
    check("f55_status", 32'(rx_status), 32'h1);
    check("f55_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("f55_overrun", 32'(overrun), 32'h0);
    pulse_clear();
    settle();
    check("clr_status", 32'(rx_status), 32'h0);

    // Short low glitch is rejected
    v0 = valid_cnt;
    line(1'b0, 3 * DIV);
    line(1'b1, 2 * BIT);
    settle();
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_idle", 32'(dut.r_state), 32'(ST_IDLE));
    send_frame(8'hC3, 1'b1);
    line(1'b1, BIT);
    settle();
    check("fC3_data", 32'(rx_data), 32'hC3);
    check("fC3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    pulse_clear();

    // Framing error with a held-low line
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0);
    line(1'b0, 2 * BIT);
    settle();
    check("brk_state", 32'(dut.r_state), 32'(ST_BREAK));
    check("brk_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("brk_ferr_width", 32'(ferr_max), 32'd1);
    check("brk_valid", 32'(valid_cnt - v0), 32'd0);
    check("brk_data_kept", 32'(rx_data), 32'hC3);
    check("brk_status", 32'(rx_status), 32'h0);
    line(1'b1, 2 * BIT);
    settle();
    check("brk_no_retrigger", 32'(ferr_cnt - f0), 32'd1);
    check("brk_exit_idle", 32'(dut.r_state), 32'(ST_IDLE));
    send_frame(8'h0F, 1'b1);
    line(1'b1, BIT);
    settle();
    check("f0F_data", 32'(rx_data), 32'h0F);
    check("f0F_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    pulse_clear();

    // Overrun
    send_frame(8'h12, 1'b1);
    line(1'b1, BIT);
    settle();
    check("f12_data", 32'(rx_data), 32'h12);
    check("f12_overrun", 32'(overrun), 32'h0);
    send_frame(8'h34, 1'b1);
    line(1'b1, BIT);
    settle();
    check("ovr_overrun", 32'(overrun), 32'h1);
    check("ovr_data", 32'(rx_data), 32'h34);
    check("ovr_status", 32'(rx_status), 32'h1);
    pulse_clear();
    settle();
    check("ovr_clr_status", 32'(rx_status), 32'h0);
    check("ovr_clr_overrun", 32'(overrun), 32'h0);

    // Reset during data bit 4 of 0xFF
    v0 = valid_cnt;
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(1'b1, BIT);
    line(1'b1, BIT / 2);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    settle();
    check("mid_rst_data", 32'(rx_data), 32'h00);
    check("mid_rst_status", 32'(rx_status), 32'h0);
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset = 1'b0;
    line(1'b1, 5 * BIT);
    settle();
    check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_frame(8'h81, 1'b1);
    line(1'b1, BIT);
    settle();
    check("f81_data", 32'(rx_data), 32'h81);
    check("f81_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("f81_status", 32'(rx_status), 32'h1);

    // Clear coinciding with completion while a byte is pending
    v0 = valid_cnt;
    hit = 1'b0;
    coincide = 1'b0;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        for (int k = 0; k < 20 * BIT && !hit; k++) begin
          @(negedge clk);
          if (dut.r_state == ST_STOP && dut.r_cnt == MID_BIT_CNT && dut.w_tick) begin
            rx_clear = 1'b1;
            hit = 1'b1;
            @(negedge clk);
            coincide = rx_valid;
            rx_clear = 1'b0;
          end
        end
      end
    join
    line(1'b1, BIT);
    settle();
    check("f7E_clear_hit", 32'(hit), 32'h1);
    check("f7E_coincide", 32'(coincide), 32'h1);
    check("f7E_status", 32'(rx_status), 32'h1);
    check("f7E_overrun", 32'(overrun), 32'h0);
    check("f7E_data", 32'(rx_data), 32'h7E);
    check("f7E_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("valid_width_all", 32'(valid_max), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
